// File: rtl/seg7_write_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_write_ctrl_if
// Purpose  : Bus bundle between a CPU-side writer and the 4-digit 7-segment
//            write controller.
// Signals  : we       - write strobe (CPU -> ctrl)
//            data_in  - 16-bit value to display (CPU -> ctrl)
//            blank_lz - leading-zero blanking enable (CPU -> ctrl)
//            seg      - active-low segments g..a (ctrl -> CPU/pins)
//            dp       - active-low decimal point (ctrl -> CPU/pins)
//            an       - active-low digit enables (ctrl -> CPU/pins)
//            done     - value shown on all digits at least once (ctrl -> CPU)
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_write_ctrl_if;
  logic        we;
  logic [15:0] data_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        done;

  modport master (
    output we, data_in, blank_lz,
    input  seg, dp, an, done
  );

  modport slave (
    input  we, data_in, blank_lz,
    output seg, dp, an, done
  );
endinterface
`default_nettype wire

// File: rtl/seg7_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_write_ctrl
// Purpose  : Latches a 16-bit value on a CPU write and time-multiplexes it
//            onto a 4-digit common-anode 7-segment display, lighting each
//            digit for DIV clocks. Raises a sticky done flag once all four
//            digits of the current value have been shown.
// Ports    : clk   - system clock, rising edge
//            reset - synchronous, active-high reset
//            bus   - seg7_write_ctrl_if slave modport
//                    (we, data_in, blank_lz in; seg, dp, an, done out)
// Params   : DIV   - dwell per digit in clk cycles, 2..2^24-1
// Revision : 1.0 - initial release
// ============================================================================
module seg7_write_ctrl #(
  parameter int DIV = 100000
) (
  input wire logic         clk,
  input wire logic         reset,
  seg7_write_ctrl_if.slave bus
);

  localparam logic [23:0] CNT_LAST = 24'(DIV - 1);

  typedef enum logic [0:0] {
    SCANNING = 1'b0,
    SHOWN    = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [15:0] value_reg;
  logic [23:0] cnt;
  logic [1:0]  digit;
  logic        wrap;
  logic [3:0]  nibble;
  logic        blank;
  logic [6:0]  seg_dec;

  assign wrap = (cnt == CNT_LAST);

  // Dwell counter, digit index and captured value. A write restarts the scan
  // from digit 0 so a fresh value is always shown from the least significant
  // digit for a full rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= 16'h0000;
      cnt       <= 24'd0;
      digit     <= 2'd0;
    end else if (bus.we) begin
      value_reg <= bus.data_in;
      cnt       <= 24'd0;
      digit     <= 2'd0;
    end else if (wrap) begin
      cnt       <= 24'd0;
      digit     <= digit + 2'd1;
    end else begin
      cnt       <= cnt + 24'd1;
    end
  end

  // done FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCANNING;
    end else begin
      state <= state_next;
    end
  end

  // A write takes priority over completing the last digit, so done can never
  // be reported for a value that was overwritten on the same edge.
  always_comb begin
    state_next = state;
    if (bus.we) begin
      state_next = SCANNING;
    end else if (state == SCANNING && digit == 2'd3 && wrap) begin
      state_next = SHOWN;
    end
  end

  // Nibble select and leading-zero detection for the active digit
  always_comb begin
    nibble = value_reg[3:0];
    blank  = 1'b0;
    case (digit)
      2'd0: begin
        nibble = value_reg[3:0];
        blank  = 1'b0;
      end
      2'd1: begin
        nibble = value_reg[7:4];
        blank  = (value_reg[15:4] == 12'h000);
      end
      2'd2: begin
        nibble = value_reg[11:8];
        blank  = (value_reg[15:8] == 8'h00);
      end
      default: begin
        nibble = value_reg[15:12];
        blank  = (value_reg[15:12] == 4'h0);
      end
    endcase
  end

  // Hex to active-low segments, bit order g,f,e,d,c,b,a
  always_comb begin
    seg_dec = 7'b1111111;
    case (nibble)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      default: seg_dec = 7'b0001110;
    endcase
  end

  // blank_lz is applied live; a blanked digit still occupies its dwell slot.
  always_comb begin
    bus.an  = ~(4'b0001 << digit);
    bus.seg = seg_dec;
    if (bus.blank_lz && blank) begin
      bus.an  = 4'b1111;
      bus.seg = 7'b1111111;
    end
  end

  assign bus.dp   = 1'b1;
  assign bus.done = (state == SHOWN);

endmodule
`default_nettype wire

// File: tb/tb_seg7_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_write_ctrl
// Purpose  : Directed self-checking bench for seg7_write_ctrl with DIV=4.
//            Inputs change and outputs are sampled 1 time unit after each
//            rising clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_write_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  seg7_write_ctrl_if bus ();

  seg7_write_ctrl #(.DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] an_exp,
                          input logic [6:0] seg_exp, input logic done_exp);
    chk({tag, "_an"},   {12'h0, bus.an},   {12'h0, an_exp});
    chk({tag, "_seg"},  {9'h0, bus.seg},   {9'h0, seg_exp});
    chk({tag, "_done"}, {15'h0, bus.done}, {15'h0, done_exp});
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    bus.we       = 1'b0;
    bus.data_in  = 16'h0000;
    bus.blank_lz = 1'b0;

    // Reset for two cycles
    step(2);
    chk_disp("rst", 4'b1110, 7'b1000000, 1'b0);
    chk("rst_dp", {15'h0, bus.dp}, 16'h0001);
    reset = 1'b0;
    step(15);
    chk("rst_done15", {15'h0, bus.done}, 16'h0000);
    step(1);
    chk("rst_done16", {15'h0, bus.done}, 16'h0001);

    // Write 0x12AF, single-cycle strobe
    bus.we = 1'b1; bus.data_in = 16'h12AF;
    step(1);
    bus.we = 1'b0;
    chk_disp("w12af_d0c0", 4'b1110, 7'b0001110, 1'b0);
    step(3);
    chk_disp("w12af_d0c3", 4'b1110, 7'b0001110, 1'b0);
    step(1);
    chk_disp("w12af_d1", 4'b1101, 7'b0001000, 1'b0);
    step(4);
    chk_disp("w12af_d2", 4'b1011, 7'b0100100, 1'b0);
    step(4);
    chk_disp("w12af_d3", 4'b0111, 7'b1111001, 1'b0);
    step(3);
    chk("w12af_done15", {15'h0, bus.done}, 16'h0000);
    step(1);
    chk_disp("w12af_c16", 4'b1110, 7'b0001110, 1'b1);
    step(4);
    chk_disp("w12af_keep", 4'b1101, 7'b0001000, 1'b1);

    // Leading-zero blanking with 0x0007
    bus.blank_lz = 1'b1;
    bus.we = 1'b1; bus.data_in = 16'h0007;
    step(1);
    bus.we = 1'b0;
    chk_disp("blk_d0", 4'b1110, 7'b1111000, 1'b0);
    step(4);
    chk_disp("blk_d1", 4'b1111, 7'b1111111, 1'b0);
    bus.blank_lz = 1'b0;
    #1;
    chk_disp("blk_live_off", 4'b1101, 7'b1000000, 1'b0);
    bus.blank_lz = 1'b1;
    step(4);
    chk_disp("blk_d2", 4'b1111, 7'b1111111, 1'b0);
    step(4);
    chk_disp("blk_d3", 4'b1111, 7'b1111111, 1'b0);
    step(3);
    chk("blk_done15", {15'h0, bus.done}, 16'h0000);
    step(1);
    chk_disp("blk_c16", 4'b1110, 7'b1111000, 1'b1);
    bus.blank_lz = 1'b0;

    // Write collides with the SHOWN transition
    bus.we = 1'b1; bus.data_in = 16'h1234;
    step(1);
    bus.we = 1'b0;
    step(15);
    chk_disp("col_c15", 4'b0111, 7'b1111001, 1'b0);
    bus.we = 1'b1; bus.data_in = 16'h5678;
    step(1);
    bus.we = 1'b0;
    chk_disp("col_win", 4'b1110, 7'b0000000, 1'b0);
    step(15);
    chk("col_done15", {15'h0, bus.done}, 16'h0000);
    step(1);
    chk("col_done16", {15'h0, bus.done}, 16'h0001);

    // Multi-cycle write strobe: last edge wins and restarts timing
    bus.we = 1'b1; bus.data_in = 16'h0003;
    step(1);
    bus.data_in = 16'h0009;
    step(1);
    bus.we = 1'b0;
    chk_disp("mw_d0", 4'b1110, 7'b0010000, 1'b0);
    step(15);
    chk("mw_done15", {15'h0, bus.done}, 16'h0000);
    step(1);
    chk("mw_done16", {15'h0, bus.done}, 16'h0001);

    // Reset mid-scan
    bus.we = 1'b1; bus.data_in = 16'hFFFF;
    step(1);
    bus.we = 1'b0;
    step(9);
    chk_disp("mid_d2", 4'b1011, 7'b0001110, 1'b0);
    reset = 1'b1;
    step(1);
    chk_disp("mid_rst", 4'b1110, 7'b1000000, 1'b0);
    reset = 1'b0;
    step(15);
    chk("mid_done15", {15'h0, bus.done}, 16'h0000);
    step(1);
    chk("mid_done16", {15'h0, bus.done}, 16'h0001);

    // Reset overrides a simultaneous write
    reset = 1'b1; bus.we = 1'b1; bus.data_in = 16'h8888;
    step(1);
    reset = 1'b0; bus.we = 1'b0;
    chk_disp("rw_same", 4'b1110, 7'b1000000, 1'b0);
    step(4);
    chk_disp("rw_d1", 4'b1101, 7'b1000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_write_ctrl.md
SEG7_WRITE_CTRL -- requirements
Module: seg7_write_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 100000, meaning clk cycles each digit is lit; legal range 2..2^24-1.
REQ-002 The block SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1: reset, synchronous, active-high; clock clk.
REQ-004 The block SHALL have port we, input, 1, CPU write strobe, one or more cycles, sampled on every clk edge.
REQ-005 The block SHALL have port data_in, input, 16, value to display, captured when we=1.
REQ-006 The block SHALL have port blank_lz, input, 1, leading-zero blanking enable, sampled live.
REQ-007 The block SHALL have port seg, output, 7, active-low segments, seg[6:0] = g,f,e,d,c,b,a.
REQ-008 The block SHALL have port dp, output, 1, active-low decimal point, constant 1 (off).
REQ-009 The block SHALL have port an, output, 4, active-low digit enables, exactly one or zero bits low.
REQ-010 The block SHALL have port done, output, 1, sticky flag: current value shown on all four digits at least once.

Function
REQ-011 On a clk edge with we=1: value_reg <= data_in, dwell counter <= 0, digit index <= 0, done <= 0.
REQ-012 With we=0, dwell counter SHALL increment each cycle and wrap to 0 after reaching DIV-1; on that wrap digit index SHALL advance 0->1->2->3->0.
REQ-013 Digit index k SHALL drive an with bit k low and others high (0:1110, 1:1101, 2:1011, 3:0111) and display nibble value_reg[4k+3:4k].
REQ-014 seg SHALL be combinational from registered state (zero added latency): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-015 With blank_lz=1, digit k>=1 SHALL be blanked (an=1111, seg=1111111) when nibbles k..3 are all zero; digit 0 is never blanked.
REQ-016 done FSM: states SCANNING, SHOWN; SCANNING->SHOWN on the edge where digit index is 3 and counter wraps (we=0); SHOWN->SCANNING on we=1; done=1 only in SHOWN.
REQ-017 done SHALL rise exactly 4*DIV cycles after the edge that captured we=1, provided we stays low.
REQ-018 we=1 on the same edge as a SHOWN transition: write SHALL win; done stays 0, scan restarts at digit 0.
REQ-019 we held high for N cycles: each edge recaptures data_in and restarts; done rises 4*DIV cycles after the last we=1 edge.
REQ-020 Blanked digits still consume their full DIV dwell and count toward done.
REQ-021 In SHOWN the scan SHALL continue indefinitely; done remains 1 until we or reset.

Reset
REQ-022 On reset=1 at a clk edge: value_reg=0, counter=0, digit index=0, FSM=SCANNING; overrides simultaneous we.
REQ-023 Outputs in the cycle after reset: an=1110, seg=1000000, dp=1, done=0.
REQ-024 Reset mid-scan or in SHOWN SHALL abort scanning immediately; done re-rises 4*DIV cycles after reset deasserts.

Verification (DIV=4)
REQ-025 Reset 2 cycles, release -> an=1110, seg=1000000, done=0; done=1 after 16 cycles.
REQ-026 we=1 one cycle with data_in=0x12AF -> digit0 seg=0001110 (F) cycles 0-3, digit1 0001000 (A), digit2 0100100 (2), digit3 1111001 (1); done=1 at cycle 16.
REQ-027 blank_lz=1, write 0x0007 -> digit0 shows 1111000; digits 1-3 an=1111, seg=1111111; done still at cycle 16.
REQ-028 Write 0x1234, then we=1 with 0x5678 at cycle 15 -> done stays 0, digit0 shows 8 next cycle, done at 16 cycles after second write.
REQ-029 Write 0xFFFF, assert reset at cycle 9 -> an=1110, seg=1000000, done=0; done=1 16 cycles after reset release.
REQ-030 reset=1 and we=1 same edge with data_in=0x8888 -> value stays 0, seg=1000000.
